// File: rtl/seq_alu.sv
// Handshaked ALU: add/sub/neg/and/or in one cycle, shift-add MUL and restoring MOD over WIDTH cycles.
// Define SEQ_ALU_MULDIV_EN to build the multiply/divide unit; otherwise ops 110/111 return err.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NEGA = 3'b010;
    localparam logic [2:0] OP_NEGB = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_MOD  = 3'b111;

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_hi, p_lo, rem, quo;
    logic [WIDTH:0]   mul_sum, div_r;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, rem_n, quo_n;
    logic             div_ge;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd3} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] q_res, q_hi;
    logic             q_carry, q_err;

    assign in_ready = (state == IDLE);

    // Single-cycle results, computed straight from the port values in the accept cycle.
    always_comb begin
        q_res   = '0;
        q_hi    = '0;
        q_carry = 1'b0;
        q_err   = 1'b0;
        case (op)
            OP_ADD:  {q_carry, q_res} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {q_carry, q_res} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            OP_NEGA: {q_carry, q_res} = {1'b0, ~a} + (WIDTH+1)'(1);
            OP_NEGB: {q_carry, q_res} = {1'b0, ~b} + (WIDTH+1)'(1);
            OP_AND:  q_res = a & b;
            OP_OR:   q_res = a | b;
`ifdef SEQ_ALU_MULDIV_EN
            OP_MOD: begin
                q_res = a;
                q_hi  = '1;
                q_err = 1'b1;
            end
            default: q_err = 1'b0;
`else
            OP_MUL, OP_MOD: q_err = 1'b1;
            default:        q_err = 1'b0;
`endif
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    // One multiply step and one restoring-divide step per cycle.
    always_comb begin
        mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], p_lo[WIDTH-1:1]};
        div_r    = {rem, quo[WIDTH-1]};
        div_ge   = (div_r >= {1'b0, b_q});
        rem_n    = div_ge ? (div_r[WIDTH-1:0] - b_q) : div_r[WIDTH-1:0];
        quo_n    = {quo[WIDTH-2:0], div_ge};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            a_q  <= '0;
            b_q  <= '0;
            cnt  <= '0;
            p_hi <= '0;
            p_lo <= '0;
            rem  <= '0;
            quo  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
`ifdef SEQ_ALU_MULDIV_EN
                    a_q <= a;
                    b_q <= b;
                    cnt <= CW'(WIDTH - 1);
                    // Multi-cycle ops divert here; everything else falls through to the quick path.
                    if (op == OP_MUL) begin
                        p_hi  <= '0;
                        p_lo  <= b;
                        state <= MUL;
                    end else if (op == OP_MOD && b != '0) begin
                        rem   <= '0;
                        quo   <= a;
                        state <= DIV;
                    end else
`endif
                    begin
                        result    <= q_res;
                        result_hi <= q_hi;
                        carry     <= q_carry;
                        zero      <= (q_res == '0);
                        err       <= q_err;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                MUL: begin
                    p_hi <= mul_hi_n;
                    p_lo <= mul_lo_n;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result    <= mul_lo_n;
                        result_hi <= mul_hi_n;
                        carry     <= 1'b0;
                        zero      <= (mul_lo_n == '0);
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DIV: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result    <= rem_n;
                        result_hi <= quo_n;
                        carry     <= 1'b0;
                        zero      <= (rem_n == '0);
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the team's 4-bit combinational ALU: the same eight-operation set at configurable width, with a sequential shift-add multiplier and restoring divider in place of flat array logic. Operands and opcode enter through a valid/ready input port and are captured on acceptance. Results leave through a valid/ready output port with flags. The block sits between the operand register file and the writeback stage, one operation in flight at a time.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  3  opcode: 000 ADD, 001 SUB (A-B), 010 NEGA, 011 NEGB, 100 AND, 101 OR, 110 MUL, 111 MOD.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result available; held until taken.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  primary result.
- result_hi  out  WIDTH  MUL upper half; MOD quotient; 0 for all other ops.
- carry  out  1  ADD carry-out; SUB/NEG no-borrow (1 = no borrow); 0 for other ops.
- zero  out  1  result == 0.
- err  out  1  MOD with b == 0, or an unsupported op when the multiply/divide unit is compiled out.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset value: IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, op, a and b are captured into internal registers. Later input changes are ignored until the next acceptance.
- Ops 000–101 evaluate in the accept cycle and register into the output regs. Next state is DONE.
- 110: next state is MUL. Shift-add runs one partial product per cycle for WIDTH cycles. The 2·WIDTH-bit product splits into result_hi:result. Then DONE.
- 111: next state is DIV. Restoring division runs one quotient bit per cycle for WIDTH cycles. result = remainder, result_hi = quotient. Then DONE.
- MOD with b==0 skips DIV and goes directly to DONE with result=a, result_hi=all ones, err=1.
- All arithmetic is unsigned, modulo 2^WIDTH:
  - SUB = a + ~b + 1.
  - NEGA = ~a + 1, with carry=1 only when a==0.
  - NEGB = ~b + 1, with carry=1 only when b==0.
- DONE: out_valid=1 and outputs stay stable. When out_ready=1, the state returns to IDLE and out_valid drops next cycle. No new accept in the same cycle (in_ready=0 in DONE).
- Reset value of every output: in_ready=1 (derived from IDLE), all other outputs 0.
- Reset asserted mid-MUL/DIV/DONE aborts the operation, discards the result, and returns to IDLE.

## Timing
- Logic ops and ADD/SUB/NEG: out_valid rises 1 cycle after the accept edge.
- MUL and MOD with b≠0: out_valid rises WIDTH+1 cycles after the accept edge.
- MOD with b==0: out_valid rises 1 cycle after the accept edge.
- Minimum issue interval: latency + 1 cycle (the DONE→IDLE handoff).
- out_ready held low: result, result_hi and flags remain unchanged indefinitely.
- out_ready high before out_valid: no effect.

## Configuration
- SEQ_ALU_MULDIV_EN defined: MUL/DIV states, shift-add and restoring datapaths are compiled in, behaving as above.
- Not defined: ops 110 and 111 complete in 1 cycle with result=0, result_hi=0, carry=0, zero=1, err=1. The MUL/DIV states are absent.

## Test plan (WIDTH=4, SEQ_ALU_MULDIV_EN defined unless noted)
- ADD a=4'hC, b=4'h5 -> result=4'h1, carry=1, zero=0, out_valid 1 cycle after accept.
- SUB a=3, b=5 -> result=4'hE, carry=0. NEGA a=0 -> result=0, carry=1, zero=1.
- MUL a=7, b=6 -> result=4'hA, result_hi=4'h2, out_valid exactly 5 cycles after accept, in_ready=0 throughout. Changing a/b mid-operation has no effect.
- MOD a=13, b=4 -> result=1, result_hi=3 after 5 cycles. MOD a=9, b=0 -> result=9, result_hi=4'hF, err=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> outputs stable. Raise it -> IDLE next cycle, then accept the next op.
- rst_n low at cycle 2 of MUL -> all outputs 0, in_ready=1, no out_valid. Build without the macro: op=110 -> err=1, result=0 after 1 cycle.
